// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage: queue entry layout,
// in-flight tracker encoding and the bubble instruction used by downstream stages.
package fetch_pkg;

    localparam int                INST_W   = 32;
    localparam logic [31:0]       PC_STEP  = 32'd4;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    // Fate of the instruction-memory response arriving in the current cycle.
    typedef enum logic [1:0] {
        IFS_IDLE = 2'd0,
        IFS_PEND = 2'd1,
        IFS_DROP = 2'd2
    } ifs_e;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, inst} entries with wrap-around pointers and an occupancy count.
// Clear (flush on redirect) has priority over push and pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    output logic                       head_valid,
    output fetch_entry_t               head_entry,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~clear;
    assign do_pop  = pop & ~clear & (count_q != '0);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry;
    end

    assign head_valid = (count_q != '0);
    assign head_entry = head_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited fetches to a one-cycle
// synchronous instruction memory, and hands words to decode through a prefetch queue.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    output logic                       IMEM_REQ,
    output logic [31:0]                IMEM_ADDR,
    input  logic [INST_W-1:0]          IMEM_RDATA,
    input  logic                       REDIRECT,
    input  logic [31:0]                REDIRECT_PC,
    output logic                       INST_VALID,
    input  logic                       INST_READY,
    output logic [INST_W-1:0]          INST_DATA,
    output logic [31:0]                INST_PC,
    output logic [$clog2(DEPTH+1)-1:0] QUEUE_COUNT
);

    localparam int CNT_W = $clog2(DEPTH+1);

    ifs_e             state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    // PC of the request whose response arrives this cycle.
    logic [31:0]      inflight_pc_q, inflight_pc_d;

    logic             head_valid;
    fetch_entry_t     head_entry;
    fetch_entry_t     push_entry;
    logic [CNT_W-1:0] count;
    logic             pop;
    logic             push;
    logic             inflight;
    logic             issue;
    logic [CNT_W:0]   slots_claimed;

    assign pop      = head_valid & INST_READY & ~REDIRECT;
    assign inflight = (state_q == IFS_PEND);
    assign push     = inflight & ~REDIRECT & ~RST;

    // A new request needs a slot that stays free once the arriving word lands.
    assign slots_claimed = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    assign issue         = ~RST & ~REDIRECT & (slots_claimed < (CNT_W+1)'(DEPTH));

    // NOTE: every always_comb output gets a default first, so no latches are inferred.
    always_comb begin
        state_d       = IFS_IDLE;
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;

        if (REDIRECT) begin
            fetch_pc_d = align_word(REDIRECT_PC);
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + PC_STEP;
            inflight_pc_d = fetch_pc_q;
        end

        unique case (state_q)
            IFS_IDLE: state_d = issue ? IFS_PEND : IFS_IDLE;
            IFS_PEND: state_d = issue ? IFS_PEND : IFS_IDLE;
            IFS_DROP: state_d = issue ? IFS_PEND : IFS_IDLE;
            default:  state_d = IFS_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IFS_IDLE;
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= RESET_PC;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign push_entry = '{pc: inflight_pc_q, inst: IMEM_RDATA};

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (CLK),
        .rst        (RST),
        .clear      (REDIRECT),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_valid (head_valid),
        .head_entry (head_entry),
        .count      (count)
    );

    assign IMEM_REQ    = issue;
    assign IMEM_ADDR   = RST ? RESET_PC : fetch_pc_q;
    assign INST_VALID  = head_valid;
    assign INST_DATA   = head_entry.inst;
    assign INST_PC     = head_entry.pc;
    assign QUEUE_COUNT = count;

    a_count_bounded : assert property (@(posedge CLK) disable iff (RST)
        QUEUE_COUNT <= CNT_W'(DEPTH));

    a_addr_aligned : assert property (@(posedge CLK) IMEM_ADDR[1:0] == 2'b00);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed and randomized checks of inst_fetch_unit against a word-equals-address memory.
module tb_inst_fetch_unit;

    logic        CLK;
    logic        RST;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_RDATA;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        INST_VALID;
    logic        INST_READY;
    logic [31:0] INST_DATA;
    logic [31:0] INST_PC;
    logic [1:0]  QUEUE_COUNT;

    int n_cmp = 0;
    int n_bad = 0;

    inst_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_RDATA  (IMEM_RDATA),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .INST_VALID  (INST_VALID),
        .INST_READY  (INST_READY),
        .INST_DATA   (INST_DATA),
        .INST_PC     (INST_PC),
        .QUEUE_COUNT (QUEUE_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous-read memory whose word at every address is the address itself.
    always @(posedge CLK) IMEM_RDATA <= IMEM_REQ ? IMEM_ADDR : 32'hDEAD_BEEF;

    // Called at posedge+1; holds RST over one edge and returns at the start of cycle 0.
    task automatic do_reset();
        RST      = 1'b1;
        REDIRECT = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; REDIRECT = 1'b0; REDIRECT_PC = '0; INST_READY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        n_cmp++; if (IMEM_REQ !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", IMEM_REQ); end
        n_cmp++; if (IMEM_ADDR !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 00000000", IMEM_ADDR); end
        n_cmp++; if (INST_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", INST_VALID); end
        n_cmp++; if (INST_DATA !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 00000000", INST_DATA); end
        n_cmp++; if (INST_PC !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 00000000", INST_PC); end
        n_cmp++; if (QUEUE_COUNT !== 2'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", QUEUE_COUNT); end
        @(posedge CLK); #1;
    endtask

    task automatic test_stream();
        INST_READY = 1'b1;
        do_reset();
        @(negedge CLK); // cycle 0
        n_cmp++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h0) begin n_bad++; $display("FAIL stream_c0_req: got req=%b addr=%h want req=1 addr=00000000", IMEM_REQ, IMEM_ADDR); end
        n_cmp++; if (INST_VALID !== 1'b0) begin n_bad++; $display("FAIL stream_c0_valid: got %b want 0", INST_VALID); end
        @(negedge CLK); // cycle 1
        n_cmp++; if (INST_VALID !== 1'b0 || IMEM_ADDR !== 32'h4) begin n_bad++; $display("FAIL stream_c1: got valid=%b addr=%h want valid=0 addr=00000004", INST_VALID, IMEM_ADDR); end
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK); // cycles 2..7
            n_cmp++;
            if (INST_VALID !== 1'b1 || INST_PC !== 32'(4*k) || INST_DATA !== 32'(4*k)) begin
                n_bad++;
                $display("FAIL stream_word%0d: got valid=%b pc=%h data=%h want valid=1 pc=data=%h", k, INST_VALID, INST_PC, INST_DATA, 32'(4*k));
            end
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_backpressure();
        INST_READY = 1'b0;
        do_reset();
        @(negedge CLK); // cycle 0
        n_cmp++; if (IMEM_REQ !== 1'b1) begin n_bad++; $display("FAIL bp_c0_req: got %b want 1", IMEM_REQ); end
        @(negedge CLK); // cycle 1
        n_cmp++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h4) begin n_bad++; $display("FAIL bp_c1_req: got req=%b addr=%h want req=1 addr=00000004", IMEM_REQ, IMEM_ADDR); end
        @(negedge CLK); // cycle 2
        n_cmp++; if (INST_VALID !== 1'b1 || INST_PC !== 32'h0 || QUEUE_COUNT !== 2'd1 || IMEM_REQ !== 1'b0) begin n_bad++; $display("FAIL bp_c2: got valid=%b pc=%h count=%0d req=%b want 1/00000000/1/0", INST_VALID, INST_PC, QUEUE_COUNT, IMEM_REQ); end
        @(negedge CLK); // cycle 3
        n_cmp++; if (QUEUE_COUNT !== 2'd2 || IMEM_REQ !== 1'b0 || IMEM_ADDR !== 32'h8) begin n_bad++; $display("FAIL bp_c3_full: got count=%0d req=%b addr=%h want 2/0/00000008", QUEUE_COUNT, IMEM_REQ, IMEM_ADDR); end
        @(negedge CLK); // cycle 4
        n_cmp++; if (QUEUE_COUNT !== 2'd2 || IMEM_REQ !== 1'b0 || INST_PC !== 32'h0) begin n_bad++; $display("FAIL bp_c4_hold: got count=%0d req=%b pc=%h want 2/0/00000000", QUEUE_COUNT, IMEM_REQ, INST_PC); end
        @(posedge CLK); #1;
        INST_READY = 1'b1;
        @(negedge CLK); // cycle 5: pop and request in the same cycle
        n_cmp++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h8 || INST_PC !== 32'h0) begin n_bad++; $display("FAIL bp_release: got req=%b addr=%h pc=%h want 1/00000008/00000000", IMEM_REQ, IMEM_ADDR, INST_PC); end
        for (int k = 1; k < 4; k++) begin
            @(negedge CLK);
            n_cmp++;
            if (INST_VALID !== 1'b1 || INST_PC !== 32'(4*k) || INST_DATA !== 32'(4*k)) begin
                n_bad++;
                $display("FAIL bp_drain%0d: got valid=%b pc=%h data=%h want valid=1 pc=data=%h", k, INST_VALID, INST_PC, INST_DATA, 32'(4*k));
            end
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_redirect();
        INST_READY = 1'b0;
        do_reset();              // cycle 0
        @(posedge CLK); #1;      // cycle 1
        @(posedge CLK); #1;      // cycle 2: PC 0 queued, word 4 arriving
        REDIRECT = 1'b1; REDIRECT_PC = 32'h100; INST_READY = 1'b1;
        @(negedge CLK);
        n_cmp++; if (QUEUE_COUNT !== 2'd1 || INST_VALID !== 1'b1 || IMEM_REQ !== 1'b0) begin n_bad++; $display("FAIL redir_cycle: got count=%0d valid=%b req=%b want 1/1/0", QUEUE_COUNT, INST_VALID, IMEM_REQ); end
        @(posedge CLK); #1;      // r+1
        REDIRECT = 1'b0;
        @(negedge CLK);
        n_cmp++; if (INST_VALID !== 1'b0 || QUEUE_COUNT !== 2'd0 || IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h100) begin n_bad++; $display("FAIL redir_r1: got valid=%b count=%0d req=%b addr=%h want 0/0/1/00000100", INST_VALID, QUEUE_COUNT, IMEM_REQ, IMEM_ADDR); end
        @(negedge CLK);          // r+2: killed word 4 must not show up
        n_cmp++; if (INST_VALID !== 1'b0 || QUEUE_COUNT !== 2'd0) begin n_bad++; $display("FAIL redir_r2: got valid=%b count=%0d pc=%h want valid=0 count=0", INST_VALID, QUEUE_COUNT, INST_PC); end
        @(negedge CLK);          // r+3
        n_cmp++; if (INST_VALID !== 1'b1 || INST_PC !== 32'h100 || INST_DATA !== 32'h100) begin n_bad++; $display("FAIL redir_r3: got valid=%b pc=%h data=%h want 1/00000100/00000100", INST_VALID, INST_PC, INST_DATA); end
        @(negedge CLK);          // r+4
        n_cmp++; if (INST_VALID !== 1'b1 || INST_PC !== 32'h104) begin n_bad++; $display("FAIL redir_r4: got valid=%b pc=%h want 1/00000104", INST_VALID, INST_PC); end
        @(posedge CLK); #1;
    endtask

    task automatic test_align_wrap();
        INST_READY  = 1'b1;
        REDIRECT    = 1'b1;
        REDIRECT_PC = 32'h203;
        @(posedge CLK); #1;
        REDIRECT = 1'b0;
        @(negedge CLK);
        n_cmp++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h200) begin n_bad++; $display("FAIL align_addr: got req=%b addr=%h want 1/00000200", IMEM_REQ, IMEM_ADDR); end
        @(negedge CLK);
        @(negedge CLK);
        n_cmp++; if (INST_VALID !== 1'b1 || INST_PC !== 32'h200 || INST_DATA !== 32'h200) begin n_bad++; $display("FAIL align_word: got valid=%b pc=%h data=%h want 1/00000200/00000200", INST_VALID, INST_PC, INST_DATA); end

        @(posedge CLK); #1;
        REDIRECT    = 1'b1;
        REDIRECT_PC = 32'hFFFF_FFFC;
        @(posedge CLK); #1;
        REDIRECT = 1'b0;
        @(negedge CLK);
        n_cmp++; if (IMEM_ADDR !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_addr0: got %h want fffffffc", IMEM_ADDR); end
        @(negedge CLK);
        n_cmp++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h0) begin n_bad++; $display("FAIL wrap_addr1: got req=%b addr=%h want 1/00000000", IMEM_REQ, IMEM_ADDR); end
        @(negedge CLK);
        n_cmp++; if (INST_VALID !== 1'b1 || INST_PC !== 32'hFFFF_FFFC || INST_DATA !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_word0: got valid=%b pc=%h data=%h want 1/fffffffc/fffffffc", INST_VALID, INST_PC, INST_DATA); end
        @(negedge CLK);
        n_cmp++; if (INST_VALID !== 1'b1 || INST_PC !== 32'h0 || INST_DATA !== 32'h0) begin n_bad++; $display("FAIL wrap_word1: got valid=%b pc=%h data=%h want 1/00000000/00000000", INST_VALID, INST_PC, INST_DATA); end
        @(posedge CLK); #1;
    endtask

    task automatic test_mid_reset();
        // Stream is running at PC 0x8 and up with a request in flight.
        INST_READY = 1'b1;
        RST        = 1'b1;
        @(negedge CLK);
        n_cmp++; if (IMEM_REQ !== 1'b0 || IMEM_ADDR !== 32'h0) begin n_bad++; $display("FAIL mrst_during: got req=%b addr=%h want 0/00000000", IMEM_REQ, IMEM_ADDR); end
        @(posedge CLK); #1;
        RST = 1'b0;              // cycle 0
        @(negedge CLK);
        n_cmp++; if (INST_VALID !== 1'b0 || QUEUE_COUNT !== 2'd0 || INST_PC !== 32'h0 || INST_DATA !== 32'h0) begin n_bad++; $display("FAIL mrst_outputs: got valid=%b count=%0d pc=%h data=%h want 0/0/0/0", INST_VALID, QUEUE_COUNT, INST_PC, INST_DATA); end
        n_cmp++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h0) begin n_bad++; $display("FAIL mrst_restart: got req=%b addr=%h want 1/00000000", IMEM_REQ, IMEM_ADDR); end
        @(negedge CLK);          // cycle 1
        n_cmp++; if (INST_VALID !== 1'b0) begin n_bad++; $display("FAIL mrst_stale: got valid=%b pc=%h want valid=0", INST_VALID, INST_PC); end
        @(negedge CLK);          // cycle 2
        n_cmp++; if (INST_VALID !== 1'b1 || INST_PC !== 32'h0 || INST_DATA !== 32'h0) begin n_bad++; $display("FAIL mrst_first: got valid=%b pc=%h data=%h want 1/00000000/00000000", INST_VALID, INST_PC, INST_DATA); end
        @(negedge CLK);          // cycle 3
        n_cmp++; if (INST_VALID !== 1'b1 || INST_PC !== 32'h4) begin n_bad++; $display("FAIL mrst_second: got valid=%b pc=%h want 1/00000004", INST_VALID, INST_PC); end
        @(posedge CLK); #1;
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        int          delivered;
        delivered  = 0;
        INST_READY = 1'b1;
        do_reset();
        exp_pc = 32'h0;
        for (int i = 0; i < 10000; i++) begin
            INST_READY = ($urandom_range(0, 3) != 0);
            REDIRECT   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) REDIRECT_PC = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else                           REDIRECT_PC = $urandom;
            @(negedge CLK);
            n_cmp++;
            if ($isunknown(QUEUE_COUNT) || QUEUE_COUNT > 2'd2) begin
                n_bad++; $display("FAIL rand_count cycle %0d: got %0d want <= 2", i, QUEUE_COUNT);
            end
            if (INST_VALID === 1'b1 && INST_READY && !REDIRECT) begin
                n_cmp++;
                if (INST_PC !== exp_pc || INST_DATA !== exp_pc) begin
                    n_bad++; $display("FAIL rand_order cycle %0d: got pc=%h data=%h want %h", i, INST_PC, INST_DATA, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end else if (INST_VALID !== 1'b1) begin
                n_cmp++;
                if (INST_VALID !== 1'b0 || INST_PC !== 32'h0 || INST_DATA !== 32'h0) begin
                    n_bad++; $display("FAIL rand_idle cycle %0d: got valid=%b pc=%h data=%h want 0/0/0", i, INST_VALID, INST_PC, INST_DATA);
                end
            end
            if (REDIRECT) exp_pc = REDIRECT_PC & ~32'h3;
            @(posedge CLK); #1;
        end
        REDIRECT = 1'b0;
        n_cmp++;
        if (delivered < 3000) begin
            n_bad++; $display("FAIL rand_progress: got %0d delivered want >= 3000", delivered);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_align_wrap();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
